// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, lane offsets and lane extract/merge helpers for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2
   } state_t;

   // Big-endian lanes: offset 0 is the most significant byte/half of the word
   localparam logic [1:0] OFF_B0 = 2'd0;
   localparam logic [1:0] OFF_B1 = 2'd1;
   localparam logic [1:0] OFF_B2 = 2'd2;
   localparam logic [1:0] OFF_B3 = 2'd3;
   localparam logic [1:0] OFF_H0 = 2'd0;
   localparam logic [1:0] OFF_H1 = 2'd2;

   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         OFF_B0:  b = word[31:24];
         OFF_B1:  b = word[23:16];
         OFF_B2:  b = word[15:8];
         default: b = word[7:0];
      endcase
      h = (off == OFF_H1) ? word[15:0] : word[31:16];
      case (size)
         SZ_B:    r = {{24{~uns & b[7]}}, b};
         SZ_H:    r = {{16{~uns & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      case (size)
         SZ_B: begin
            case (off)
               OFF_B0:  r = {wdata[7:0], old[23:0]};
               OFF_B1:  r = {old[31:24], wdata[7:0], old[15:0]};
               OFF_B2:  r = {old[31:16], wdata[7:0], old[7:0]};
               default: r = {old[31:8], wdata[7:0]};
            endcase
         end
         SZ_H:    r = (off == OFF_H1) ? {old[31:16], wdata[15:0]} : {wdata[15:0], old[15:0]};
         default: r = wdata;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - combinational load extract/extend and sub-word store merge
module lsu_lane_merge
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        uns,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   assign load_data = lane_extract(mem_word, size, offset, uns);
   assign merged    = lane_merge(mem_word, wdata, size, offset);

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store unit for the word-wide data memory; LSU_MISALIGN_TRAP_EN enables misalignment traps
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int MEM_AW = 8,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_din,
   output logic              mem_we,
   input  logic [XLEN-1:0]   mem_dout
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_ACCESS = ACCESS;
   localparam logic [1:0] ST_WRITE  = WRITE;

   logic [1:0]        state;
   logic              we_q;
   logic              uns_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [1:0]        off_q;
   logic [MEM_AW-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   hold_q;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   merged;
   logic [1:0]        acc_size;
   logic [1:0]        acc_off;
   logic              acc_err;
   logic              unused_addr;

   assign unused_addr = ^req_addr[XLEN-1:MEM_AW+2];

   // Reserved size behaves as a word; sub-size offset bits are aligned down
   always_comb begin
      acc_size = (req_size == SZ_RSV) ? SZ_W : req_size;
      case (acc_size)
         SZ_B:    acc_off = req_addr[1:0];
         SZ_H:    acc_off = {req_addr[1], 1'b0};
         default: acc_off = 2'b00;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      acc_err = ((req_size == SZ_H) && req_addr[0])
             || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
             || (req_size == SZ_RSV);
`else
      acc_err = 1'b0;
`endif
   end

   lsu_lane_merge u_lane (
      .size      (size_q),
      .offset    (off_q),
      .uns       (uns_q),
      .mem_word  (mem_dout),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   assign req_ready = (state == ST_IDLE);
   assign mem_addr  = addr_q;
   assign mem_din   = (state == ST_WRITE) ? hold_q : wdata_q;
   assign mem_we    = !rst && (((state == ST_ACCESS) && we_q && !err_q && (size_q == SZ_W))
                               || (state == ST_WRITE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'b00;
         off_q      <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  uns_q   <= req_unsigned;
                  err_q   <= acc_err;
                  size_q  <= acc_size;
                  off_q   <= acc_off;
                  addr_q  <= req_addr[MEM_AW+1:2];
                  wdata_q <= req_wdata;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (err_q) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  state      <= ST_IDLE;
               end else if (!we_q) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= load_data;
                  state      <= ST_IDLE;
               end else if (size_q == SZ_W) begin
                  resp_valid <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  hold_q <= merged;
                  state  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               resp_valid <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - directed scoreboard bench for data_mem_lsu with a behavioural 256x32 memory
module tb_data_mem_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic [31:0] mem_dout;

   logic [31:0] mem [0:255];

   typedef struct {
      int          acc;
      int          lat;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   we_cnt = 0;

   data_mem_lsu #(.MEM_AW(8), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_we       (mem_we),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we === 1'b1) begin
         mem[mem_addr] <= mem_din;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && resp_valid === 1'b1) begin
         n_checks++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_resp: got resp_valid=1 expected no response");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input logic expect_resp, output int acc, output logic rv_at_accept);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      for (int i = 0; i < 10 && req_ready !== 1'b1; i++) begin
         @(posedge clk);
         #1;
      end
      chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
      acc          = cyc;
      rv_at_accept = resp_valid;
      if (expect_resp) sb.push_back('{acc, lat, exp_rdata, exp_err});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int lat);
      int   a;
      logic rv;
      issue(we, size, uns, addr, wdata, exp_rdata, exp_err, lat, 1'b1, a, rv);
      req_valid = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   a1;
      int   a2;
      int   c0;
      logic rv1;
      logic rv2;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      chk("rst_mem_din", mem_din, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

      op(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      chk("sw_mem4", mem[4], 32'hDEADBEEF);
      op(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      op(1'b1, SZ_B, 1'b0, 32'h11, 32'h0000005A, 32'h0, 1'b0, 3);
      chk("sb_mem4", mem[4], 32'hDE5ABEEF);
      op(1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h0000005A, 1'b0, 2);

      op(1'b0, SZ_B, 1'b0, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
      op(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
      op(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 2);
      op(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
      op(1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h0000DE5A, 1'b0, 2);
      op(1'b1, SZ_H, 1'b0, 32'h16, 32'h0000A5C3, 32'h0, 1'b0, 3);
      chk("sh_mem5", mem[5], 32'h0000A5C3);
      op(1'b0, SZ_H, 1'b0, 32'h16, 32'h0, 32'hFFFFA5C3, 1'b0, 2);
      op(1'b0, SZ_W, 1'b0, 32'h410, 32'h0, 32'hDE5ABEEF, 1'b0, 2);

      issue(1'b1, SZ_W, 1'b0, 32'h0, 32'h13579BDF, 32'h0, 1'b0, 2, 1'b1, a1, rv1);
      issue(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h13579BDF, 1'b0, 2, 1'b1, a2, rv2);
      req_valid = 1'b0;
      chk("b2b_accept_gap", 32'(a2 - a1), 32'd2);
      chk("b2b_resp_at_accept", {31'b0, rv2}, 32'd1);
      drain();
      chk("b2b_mem0", mem[0], 32'h13579BDF);

      mem[8] = 32'h11223344;
      issue(1'b1, SZ_H, 1'b0, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b0, a1, rv1);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("write_state_mem_we", {31'b0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_gates_mem_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("ready_after_mid_rst", {31'b0, req_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_mem8", mem[8], 32'h11223344);

      c0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
      op(1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 2);
      op(1'b1, SZ_H, 1'b0, 32'h15, 32'h00007777, 32'h0, 1'b1, 2);
      op(1'b0, SZ_RSV, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2);
      chk("trap_no_write", 32'(we_cnt - c0), 32'd0);
      op(1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'h0000A5C3, 1'b0, 2);
`else
      op(1'b0, SZ_W, 1'b0, 32'h13, 32'h0, 32'hDE5ABEEF, 1'b0, 2);
      chk("misaligned_load_no_write", 32'(we_cnt - c0), 32'd0);
      op(1'b1, SZ_H, 1'b0, 32'h15, 32'h00007777, 32'h0, 1'b0, 3);
      op(1'b0, SZ_RSV, 1'b0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0, 2);
      op(1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'h7777A5C3, 1'b0, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
